// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch handshake controller.
// Takes the PC's fetch address, runs a single outstanding read on the
// instruction port, and returns a one-cycle ihit with the fetched word.
// Defers to data-side traffic, drops responses made stale by a redirect,
// and traps misaligned fetch addresses in an absorbing fault state.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   imemaddr     fetch address from PC block
//   fetch_en     pipeline requests a new instruction
//   dbusy        data access pending, blocks launch
//   flush        redirect, outstanding fetch becomes stale
//   halt         blocks new launches only
//   iREN/iaddr   read request to memory (address frozen during request)
//   iwait/iload  memory busy flag / read data
//   ihit/instr   one-cycle valid pulse / last fetched instruction
//   misalign     sticky misaligned-fetch fault
//   fetch_cnt    count of ihit pulses (wrapping)
module ifetch_ctrl #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] imemaddr,
   input  logic              fetch_en,
   input  logic              dbusy,
   input  logic              flush,
   input  logic              halt,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload,
   output logic              ihit,
   output logic [WORD_W-1:0] instr,
   output logic              misalign,
   output logic [CNT_W-1:0]  fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_DISCARD = 3'd2,
      S_DONE    = 3'd3,
      S_FAULT   = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              iren_q, iren_d;
   logic [WORD_W-1:0] iaddr_q, iaddr_d;
   logic              ihit_q, ihit_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic              misalign_q, misalign_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              launch_c;

   assign launch_c = fetch_en & ~halt & ~dbusy & ~flush;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      iaddr_d    = iaddr_q;
      instr_d    = instr_q;
      misalign_d = misalign_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (launch_c) begin
               if (imemaddr[1:0] == 2'b00) begin
                  iaddr_d = imemaddr;
                  state_d = S_REQ;
               end else begin
                  misalign_d = 1'b1;
                  state_d    = S_FAULT;
               end
            end
         end
         S_REQ: begin
            // Flush wins over a same-cycle completion: that response is dropped.
            if (flush) begin
               state_d = iwait ? S_DISCARD : S_IDLE;
            end else if (!iwait) begin
               instr_d = iload;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_DONE;
            end
         end
         S_DISCARD: begin
            if (!iwait) state_d = S_IDLE;
         end
         S_DONE: begin
            // Forced return to IDLE lets the PC advance before the next launch.
            state_d = S_IDLE;
         end
         S_FAULT: begin
            misalign_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the state being entered.
      iren_d = (state_d == S_REQ) || (state_d == S_DISCARD);
      ihit_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         iren_q     <= 1'b0;
         iaddr_q    <= '0;
         ihit_q     <= 1'b0;
         instr_q    <= '0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         iren_q     <= iren_d;
         iaddr_q    <= iaddr_d;
         ihit_q     <= ihit_d;
         instr_q    <= instr_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign iREN      = iren_q;
   assign iaddr     = iaddr_q;
   assign ihit      = ihit_q;
   assign instr     = instr_q;
   assign misalign  = misalign_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl (CNT_W=4 to exercise counter wrap).
// Stimulus pushes the expected {instr, fetch_cnt} of every fetch that should
// complete; a monitor pops and compares on each ihit pulse.
module tb_ifetch_ctrl;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [WORD_W-1:0] imemaddr;
   logic              fetch_en, dbusy, flush, halt;
   logic              iren;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;
   logic              ihit;
   logic [WORD_W-1:0] instr;
   logic              misalign;
   logic [CNT_W-1:0]  fetch_cnt;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   ifetch_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .CLK(clk), .RST(rst), .imemaddr(imemaddr), .fetch_en(fetch_en),
      .dbusy(dbusy), .flush(flush), .halt(halt), .iREN(iren), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .ihit(ihit), .instr(instr),
      .misalign(misalign), .fetch_cnt(fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " iREN"}, 32'(iren), 32'd0);
      check({tag, " iaddr"}, iaddr, 32'd0);
      check({tag, " ihit"}, 32'(ihit), 32'd0);
      check({tag, " instr"}, instr, 32'd0);
      check({tag, " misalign"}, 32'(misalign), 32'd0);
      check({tag, " fetch_cnt"}, 32'(fetch_cnt), 32'd0);
   endtask

   task automatic push_exp(input logic [WORD_W-1:0] i, input logic [CNT_W-1:0] c);
      exp_t e;
      e.instr = i;
      e.cnt   = c;
      exp_q.push_back(e);
   endtask

   // Monitor: every ihit must match the oldest expected fetch.
   initial begin
      forever begin
         @(negedge clk);
         if (ihit === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected ihit", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("ihit instr", instr, e.instr);
               check("ihit fetch_cnt", 32'(fetch_cnt), 32'(e.cnt));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; imemaddr = '0; fetch_en = 1'b0; dbusy = 1'b0;
      flush = 1'b0; halt = 1'b0; iwait = 1'b1; iload = '0;
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Zero-wait fetch
      imemaddr = 32'h40; fetch_en = 1'b1; iwait = 1'b0; iload = 32'h8C220004;
      push_exp(32'h8C220004, 4'd1);
      tick();
      check("zw iREN", 32'(iren), 32'd1);
      check("zw iaddr", iaddr, 32'h40);
      fetch_en = 1'b0;
      tick();
      check("zw iREN in DONE", 32'(iren), 32'd0);
      tick();
      check("zw ihit one cycle", 32'(ihit), 32'd0);

      // Wait states with address freeze
      imemaddr = 32'h40; fetch_en = 1'b1; iwait = 1'b1; iload = 32'h0BADF00D;
      tick();
      imemaddr = 32'h44; fetch_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("ws iaddr frozen", iaddr, 32'h40);
         check("ws iREN", 32'(iren), 32'd1);
         tick();
      end
      iwait = 1'b0; iload = 32'h12345678;
      push_exp(32'h12345678, 4'd2);
      check("ws iaddr 4th", iaddr, 32'h40);
      tick();
      iwait = 1'b1; iload = 32'hFFFFFFFF;
      tick();

      // Flush mid-request, then fresh launch at the new address
      imemaddr = 32'h80; fetch_en = 1'b1; iwait = 1'b1;
      tick();
      fetch_en = 1'b0; imemaddr = 32'h100;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl iREN in DISCARD", 32'(iren), 32'd1);
      tick();
      iwait = 1'b0; iload = 32'hDEADBEEF;
      tick();
      check("fl iREN after", 32'(iren), 32'd0);
      check("fl instr kept", instr, 32'h12345678);
      check("fl fetch_cnt kept", 32'(fetch_cnt), 32'd2);
      fetch_en = 1'b1; iload = 32'hA0A0A0A0;
      push_exp(32'hA0A0A0A0, 4'd3);
      tick();
      check("fl relaunch iaddr", iaddr, 32'h100);
      fetch_en = 1'b0;
      tick(); tick();

      // Flush and completion in the same REQ cycle: dropped
      imemaddr = 32'h200; fetch_en = 1'b1; iwait = 1'b1;
      tick();
      fetch_en = 1'b0; flush = 1'b1; iwait = 1'b0; iload = 32'h55555555;
      tick();
      flush = 1'b0;
      check("fl+done iREN", 32'(iren), 32'd0);
      check("fl+done instr", instr, 32'hA0A0A0A0);
      tick();

      // dbusy blocks launch; halt lets the in-flight fetch finish
      dbusy = 1'b1; fetch_en = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("dbusy iREN", 32'(iren), 32'd0);
      end
      dbusy = 1'b0;
      tick();
      check("dbusy launch iREN", 32'(iren), 32'd1);
      check("dbusy launch iaddr", iaddr, 32'h300);
      halt = 1'b1;
      tick();
      iwait = 1'b0; iload = 32'h33333333;
      push_exp(32'h33333333, 4'd4);
      tick();
      iwait = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("halt no iREN", 32'(iren), 32'd0);
      end
      halt = 1'b0; fetch_en = 1'b0;
      tick();

      // Reset mid-request
      imemaddr = 32'h400; fetch_en = 1'b1; iwait = 1'b1;
      tick();
      fetch_en = 1'b0; rst = 1'b1;
      tick();
      check_reset_outputs("rst mid-req");
      rst = 1'b0;
      tick();

      // 17 fetches wrap the 4-bit counter to 1
      iwait = 1'b0;
      for (int i = 0; i < 17; i++) begin
         imemaddr = 32'(i * 4); iload = 32'h1000 + 32'(i); fetch_en = 1'b1;
         push_exp(32'h1000 + 32'(i), 4'((i + 1) % 16));
         tick();
         fetch_en = 1'b0;
         tick(); tick();
      end
      check("wrap fetch_cnt", 32'(fetch_cnt), 32'd1);

      // Misaligned fetch is absorbing until reset
      imemaddr = 32'h42; fetch_en = 1'b1; iwait = 1'b0;
      tick();
      check("mis misalign", 32'(misalign), 32'd1);
      check("mis iREN", 32'(iren), 32'd0);
      imemaddr = 32'h40;
      for (int k = 0; k < 6; k++) begin
         fetch_en = ~fetch_en;
         tick();
         check("fault iREN", 32'(iren), 32'd0);
         check("fault misalign", 32'(misalign), 32'd1);
      end
      fetch_en = 1'b0; rst = 1'b1;
      tick();
      check_reset_outputs("fault reset");
      rst = 1'b0;
      tick(); tick();

      check("outstanding expected fetches", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
